// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle instruction sequencer for the simple RISC CPU. Fetches 16-bit
// instructions over a req/ack port, decodes the opcode into ALU steering,
// and steps the datapath through FETCH -> DECODE -> EXEC (-> MULWAIT) -> WB.
// MUL is handed to an external multiplier with a start/done handshake.
// HALT or an illegal opcode parks the sequencer until reset.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   run                start level, sampled only in IDLE
//   imem_req/addr      fetch request and address (current pc)
//   imem_ack/rdata     fetch acknowledge, instruction word valid with ack
//   rd, rs1, rs2       register fields of the instruction register
//   alu_control/src    ALU operation and immediate select
//   mul_start/done     multiplier handshake
//   reg_write          one-cycle register-file write strobe
//   halted, illegal    stop status; illegal is sticky
//   instr_count        saturating count of retired instructions
module cpu_sequencer #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ack,
  input  logic [15:0]          imem_rdata,
  output logic [3:0]           rd,
  output logic [3:0]           rs1,
  output logic [3:0]           rs2,
  output logic [2:0]           alu_control,
  output logic                 alu_src,
  output logic                 mul_start,
  input  logic                 mul_done,
  output logic                 reg_write,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_MULWAIT = 3'd4;
  localparam logic [2:0] S_WB      = 3'd5;
  localparam logic [2:0] S_HALT    = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0]          state;
  logic [2:0]          next_state;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         ir;
  logic [3:0]          opcode;
  logic                retire;

  assign opcode    = ir[15:12];
  assign rd        = ir[11:8];
  assign rs1       = ir[7:4];
  assign rs2       = ir[3:0];
  assign imem_addr = pc;

  // An instruction retires either in WB or, for NOP, directly out of DECODE.
  assign retire = (state == S_WB) || ((state == S_DECODE) && (opcode == OP_NOP));

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:    if (run) next_state = S_FETCH;
      S_FETCH:   if (imem_ack) next_state = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_ADD, OP_SUB, OP_MUL, OP_ADDI: next_state = S_EXEC;
          OP_NOP:                          next_state = S_FETCH;
          default:                         next_state = S_HALT;
        endcase
      end
      // mul_done is deliberately not looked at here.
      S_EXEC:    next_state = (opcode == OP_MUL) ? S_MULWAIT : S_WB;
      S_MULWAIT: if (mul_done) next_state = S_WB;
      S_WB:      next_state = S_FETCH;
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_IDLE;
    endcase
  end

  // Strobes and status are flops loaded from next_state, so each output is
  // a clean register that already reflects the state being entered.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      alu_control <= 3'b000;
      alu_src     <= 1'b0;
      imem_req    <= 1'b0;
      mul_start   <= 1'b0;
      reg_write   <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state     <= next_state;
      imem_req  <= (next_state == S_FETCH);
      mul_start <= (next_state == S_EXEC) && (opcode == OP_MUL);
      reg_write <= (next_state == S_WB);
      halted    <= (next_state == S_HALT);

      if ((state == S_FETCH) && imem_ack) begin
        ir <= imem_rdata;
        pc <= pc + PC_WIDTH'(1);
      end

      // ALU steering is loaded only in DECODE and holds until the next one.
      if (state == S_DECODE) begin
        alu_control <= 3'b000;
        alu_src     <= 1'b0;
        unique case (opcode)
          OP_SUB:  alu_control <= 3'b001;
          OP_MUL:  alu_control <= 3'b100;
          OP_ADDI: alu_src     <= 1'b1;
          OP_ADD, OP_NOP, OP_HALT: ;
          default: illegal <= 1'b1;
        endcase
      end

      if (retire && (instr_count != '1)) begin
        instr_count <= instr_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
